// File: rtl/adc_avg_pkg.sv
// Shared types and constants for the ADC channel averager.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package adc_avg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_RUN   = 2'd2,
    ST_STOP  = 2'd3
  } seq_state_t;

  // Sequencer command register words: bit0 = run, mode field 0 = continuous.
  localparam logic [31:0] CMD_RUN  = 32'h0000_0001;
  localparam logic [31:0] CMD_STOP = 32'h0000_0000;

  // The sequencer exposes a single command register at offset 0.
  localparam logic CSR_ADDR_CMD = 1'b0;

endpackage

// File: rtl/adc_avg_seq_ctrl.sv
// Sequencer control: IDLE/START/RUN/STOP FSM issuing paired run/stop CSR writes.
// Latency: enable sampled at one edge enters START on that edge; RUN follows one edge later.
// Backpressure: none; the CSR write is a single-cycle fire-and-forget strobe.
module adc_seq_ctrl
  import adc_avg_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic        csr_write,
  output logic [31:0] csr_writedata,
  output logic        running,
  output logic        in_idle
);

  seq_state_t state;
  seq_state_t state_nxt;

  // State register; reset abandons any run without a stop write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and CSR strobes; START and STOP each last exactly one cycle so
  // every run write is followed by exactly one stop write.
  always_comb begin
    state_nxt     = state;
    csr_write     = 1'b0;
    csr_writedata = CMD_STOP;
    running       = 1'b0;
    in_idle       = 1'b0;
    case (state)
      ST_IDLE: begin
        in_idle = 1'b1;
        if (enable) state_nxt = ST_START;
      end
      ST_START: begin
        csr_write     = 1'b1;
        csr_writedata = CMD_RUN;
        state_nxt     = ST_RUN;
      end
      ST_RUN: begin
        running = 1'b1;
        if (!enable) state_nxt = ST_STOP;
      end
      ST_STOP: begin
        csr_write     = 1'b1;
        csr_writedata = CMD_STOP;
        state_nxt     = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/adc_channel_averager.sv
// Per-channel ADC averager: accumulates 2^AVG_LOG2 samples per slot, emits the truncated mean.
// Latency: result visible one cycle after the completing sample edge.
// Backpressure: one-entry output register; a result completing while it is held is dropped (sticky overrun).
module adc_channel_averager
  import adc_avg_pkg::*;
#(
  parameter int NUM_CH   = 9,
  parameter int DATA_W   = 12,
  parameter int CH_W     = 5,
  parameter int AVG_LOG2 = 4
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic              enable,
  input  logic              rsp_valid,
  input  logic [CH_W-1:0]   rsp_channel,
  input  logic [DATA_W-1:0] rsp_data,
  output logic              csr_address,
  output logic              csr_write,
  output logic [31:0]       csr_writedata,
  output logic              csr_read,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [CH_W-1:0]   res_channel,
  output logic [DATA_W-1:0] res_data,
  output logic              running,
  output logic              overrun,
  output logic [15:0]       discard_cnt
);

  localparam int ACC_W = DATA_W + AVG_LOG2;
  // A zero-bit counter is not legal; with AVG_LOG2=0 the counter stays at 0
  // and every sample completes immediately.
  localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [CH_W-1:0]  NUM_CH_C = CH_W'(NUM_CH);

  logic [ACC_W-1:0] acc [NUM_CH];
  logic [CNT_W-1:0] cnt [NUM_CH];

  logic             in_idle;
  logic             slot_hit;
  logic             disc_hit;
  logic [ACC_W-1:0] sel_acc;
  logic [CNT_W-1:0] sel_cnt;
  logic [ACC_W-1:0] sum;
  logic             complete;
  logic             res_load;
  logic             res_drop;
  logic             enable_q;
  logic             enable_rise;

  adc_seq_ctrl u_seq_ctrl (
    .clk           (clk_clk),
    .rst           (reset_reset),
    .enable        (enable),
    .csr_write     (csr_write),
    .csr_writedata (csr_writedata),
    .running       (running),
    .in_idle       (in_idle)
  );

  assign csr_address = CSR_ADDR_CMD;
  assign csr_read    = 1'b0;

  assign slot_hit = running && rsp_valid && (rsp_channel <  NUM_CH_C);
  assign disc_hit = running && rsp_valid && (rsp_channel >= NUM_CH_C);

  // Select the addressed slot's accumulator and counter.
  always_comb begin
    sel_acc = '0;
    sel_cnt = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rsp_channel == CH_W'(i)) begin
        sel_acc = acc[i];
        sel_cnt = cnt[i];
      end
    end
  end

  // The running sum cannot overflow: at most 2^AVG_LOG2 full-scale samples.
  assign sum      = sel_acc + ACC_W'(rsp_data);
  assign complete = slot_hit && (sel_cnt == CNT_LAST);
  assign res_load = complete && (!res_valid || res_ready);
  assign res_drop = complete && res_valid && !res_ready;

  assign enable_rise = enable && !enable_q;

  // Slot accumulators: cleared while idle, restart after each completed block.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        acc[i] <= '0;
        cnt[i] <= '0;
      end
    end else if (in_idle) begin
      for (int i = 0; i < NUM_CH; i++) begin
        acc[i] <= '0;
        cnt[i] <= '0;
      end
    end else if (slot_hit) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (rsp_channel == CH_W'(i)) begin
          if (complete) begin
            acc[i] <= '0;
            cnt[i] <= '0;
          end else begin
            acc[i] <= sum;
            cnt[i] <= cnt[i] + CNT_W'(1);
          end
        end
      end
    end
  end

  // One-entry result register; an accept on the completion edge frees the
  // slot for the new result in the same cycle.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      res_valid   <= 1'b0;
      res_channel <= '0;
      res_data    <= '0;
    end else if (res_load) begin
      res_valid   <= 1'b1;
      res_channel <= rsp_channel;
      res_data    <= DATA_W'(sum >> AVG_LOG2);
    end else if (res_ready) begin
      res_valid   <= 1'b0;
    end
  end

  // Sticky overrun; a new run (enable rising) clears it, a drop on that same
  // edge still sets it.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      enable_q <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      enable_q <= enable;
      overrun  <= (overrun && !enable_rise) || res_drop;
    end
  end

  // Saturating count of responses addressed beyond the configured slots.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      discard_cnt <= '0;
    end else if (disc_hit && (discard_cnt != 16'hFFFF)) begin
      discard_cnt <= discard_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_adc_channel_averager.sv
// Bench for adc_channel_averager: two instances (AVG_LOG2=4 and 2) on shared stimulus.
// Expected results come from a per-channel sum/count model and go through scoreboard queues.
// A negedge monitor pops and compares on every result handshake.
module tb_adc_channel_averager;

  localparam int NUM_CH = 9;

  logic        clk_clk = 1'b0;
  logic        reset_reset = 1'b1;
  logic        enable = 1'b0;
  logic        rsp_valid = 1'b0;
  logic [4:0]  rsp_channel = '0;
  logic [11:0] rsp_data = '0;
  logic        res_ready = 1'b0;

  logic        a_csr_address, a_csr_write, a_csr_read, a_res_valid, a_running, a_overrun;
  logic [31:0] a_csr_writedata;
  logic [4:0]  a_res_channel;
  logic [11:0] a_res_data;
  logic [15:0] a_discard_cnt;
  logic        b_csr_address, b_csr_write, b_csr_read, b_res_valid, b_running, b_overrun;
  logic [31:0] b_csr_writedata;
  logic [4:0]  b_res_channel;
  logic [11:0] b_res_data;
  logic [15:0] b_discard_cnt;

  adc_channel_averager #(.NUM_CH(NUM_CH), .DATA_W(12), .CH_W(5), .AVG_LOG2(4)) dut_a (
    .clk_clk(clk_clk), .reset_reset(reset_reset), .enable(enable),
    .rsp_valid(rsp_valid), .rsp_channel(rsp_channel), .rsp_data(rsp_data),
    .csr_address(a_csr_address), .csr_write(a_csr_write), .csr_writedata(a_csr_writedata),
    .csr_read(a_csr_read), .res_valid(a_res_valid), .res_ready(res_ready),
    .res_channel(a_res_channel), .res_data(a_res_data), .running(a_running),
    .overrun(a_overrun), .discard_cnt(a_discard_cnt)
  );

  adc_channel_averager #(.NUM_CH(NUM_CH), .DATA_W(12), .CH_W(5), .AVG_LOG2(2)) dut_b (
    .clk_clk(clk_clk), .reset_reset(reset_reset), .enable(enable),
    .rsp_valid(rsp_valid), .rsp_channel(rsp_channel), .rsp_data(rsp_data),
    .csr_address(b_csr_address), .csr_write(b_csr_write), .csr_writedata(b_csr_writedata),
    .csr_read(b_csr_read), .res_valid(b_res_valid), .res_ready(res_ready),
    .res_channel(b_res_channel), .res_data(b_res_data), .running(b_running),
    .overrun(b_overrun), .discard_cnt(b_discard_cnt)
  );

  always #5 clk_clk = ~clk_clk;

  int total = 0;
  int bad = 0;

  // Reference model: phase 0 idle, 1 run write, 2 running, 3 stop write.
  int m_phase;
  int m_en_prev;
  int m_disc;
  int m_occ [2];
  int m_ovr [2];
  int m_sum [2][NUM_CH];
  int m_num [2][NUM_CH];
  int exp_a [$];
  int exp_b [$];

  function automatic int lg(input int k);
    return (k == 0) ? 4 : 2;
  endfunction

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_en_prev = 0; m_disc = 0;
    for (int k = 0; k < 2; k++) begin
      m_occ[k] = 0; m_ovr[k] = 0;
      for (int c = 0; c < NUM_CH; c++) begin m_sum[k][c] = 0; m_num[k][c] = 0; end
    end
    exp_a.delete();
    exp_b.delete();
  endtask

  // Apply the spec rules for the upcoming clock edge using the driven inputs.
  task automatic model_edge();
    int  ch;
    int  res;
    bit  done;
    bit  drop;
    bit  rise;
    ch   = int'(rsp_channel);
    rise = enable && (m_en_prev == 0);
    for (int k = 0; k < 2; k++) begin
      done = 0; res = 0;
      if (m_phase == 2 && rsp_valid && ch < NUM_CH) begin
        m_sum[k][ch] += int'(rsp_data);
        m_num[k][ch] += 1;
        if (m_num[k][ch] == (1 << lg(k))) begin
          res = m_sum[k][ch] / (1 << lg(k));
          done = 1;
          m_sum[k][ch] = 0; m_num[k][ch] = 0;
        end
      end
      drop = done && (m_occ[k] != 0) && !res_ready;
      if (done && !drop) begin
        if (k == 0) exp_a.push_back(ch * 65536 + res);
        else        exp_b.push_back(ch * 65536 + res);
        m_occ[k] = 1;
      end else if (res_ready) begin
        m_occ[k] = 0;
      end
      m_ovr[k] = ((m_ovr[k] != 0) && !rise) || drop;
    end
    if (m_phase == 2 && rsp_valid && ch >= NUM_CH && m_disc < 65535) m_disc++;
    m_en_prev = enable;
    case (m_phase)
      0: m_phase = enable ? 1 : 0;
      1: m_phase = 2;
      2: m_phase = enable ? 2 : 3;
      default: m_phase = 0;
    endcase
    if (m_phase == 0) begin
      for (int k = 0; k < 2; k++)
        for (int c = 0; c < NUM_CH; c++) begin m_sum[k][c] = 0; m_num[k][c] = 0; end
    end
  endtask

  task automatic check_outputs();
    check("a_csr_write", a_csr_write, (m_phase == 1 || m_phase == 3) ? 1 : 0);
    check("b_csr_write", b_csr_write, (m_phase == 1 || m_phase == 3) ? 1 : 0);
    if (a_csr_write) check("a_csr_writedata", int'(a_csr_writedata), (m_phase == 1) ? 1 : 0);
    check("a_running", a_running, (m_phase == 2) ? 1 : 0);
    check("b_running", b_running, (m_phase == 2) ? 1 : 0);
    check("a_res_valid", a_res_valid, m_occ[0]);
    check("b_res_valid", b_res_valid, m_occ[1]);
    check("a_overrun", a_overrun, m_ovr[0]);
    check("b_overrun", b_overrun, m_ovr[1]);
    check("a_discard_cnt", int'(a_discard_cnt), m_disc);
    check("b_discard_cnt", int'(b_discard_cnt), m_disc);
  endtask

  task automatic cyc(input bit en, input bit v, input int ch, input int d, input bit rdy);
    enable = en; rsp_valid = v; rsp_channel = 5'(ch); rsp_data = 12'(d); res_ready = rdy;
    model_edge();
    @(posedge clk_clk);
    #1;
    check_outputs();
  endtask

  task automatic check_reset_values();
    check_outputs();
    check("a_res_channel_rst", int'(a_res_channel), 0);
    check("a_res_data_rst", int'(a_res_data), 0);
    check("b_res_data_rst", int'(b_res_data), 0);
    check("a_csr_writedata_rst", int'(a_csr_writedata), 0);
    check("a_csr_address", a_csr_address, 0);
    check("a_csr_read", a_csr_read, 0);
  endtask

  // Scoreboard monitor: a handshake happens at the next edge when valid and
  // ready are both high mid-cycle.
  always @(negedge clk_clk) begin
    int e;
    if (!reset_reset) begin
      if (a_res_valid && res_ready) begin
        if (exp_a.size() == 0) begin
          total++; bad++;
          $display("FAIL a_unexpected_result actual=ch%0d/%0d required=none", a_res_channel, a_res_data);
        end else begin
          e = exp_a.pop_front();
          check("a_res_channel", int'(a_res_channel), e / 65536);
          check("a_res_data", int'(a_res_data), e % 65536);
        end
      end
      if (b_res_valid && res_ready) begin
        if (exp_b.size() == 0) begin
          total++; bad++;
          $display("FAIL b_unexpected_result actual=ch%0d/%0d required=none", b_res_channel, b_res_data);
        end else begin
          e = exp_b.pop_front();
          check("b_res_channel", int'(b_res_channel), e / 65536);
          check("b_res_data", int'(b_res_data), e % 65536);
        end
      end
    end
  end

  initial begin
    model_reset();
    reset_reset = 1'b1;
    repeat (2) @(posedge clk_clk);
    #1;
    check_reset_values();
    reset_reset = 1'b0;
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);

    // Start: one run write, then running.
    cyc(1, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 1);

    // Channel 3: 100,101,102,104 -> 101 on the AVG_LOG2=2 instance.
    cyc(1, 1, 3, 100, 0);
    cyc(1, 1, 3, 101, 0);
    cyc(1, 1, 3, 102, 0);
    cyc(1, 1, 3, 104, 0);
    check("b_ch3_valid", b_res_valid, 1);
    check("b_ch3_data", int'(b_res_data), 101);
    cyc(1, 0, 0, 0, 1);

    // Interleaved ch0=4000 / ch1=10, accepts coinciding with completions.
    for (int i = 0; i < 16; i++) begin
      cyc(1, 1, 0, 4000, 1);
      cyc(1, 1, 1, 10, 1);
    end
    cyc(1, 0, 0, 0, 1);

    // Backpressure: completions while held are dropped and set overrun.
    for (int i = 0; i < 32; i++) cyc(1, 1, 2, 7 * i + 300, 0);
    cyc(1, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 1);

    // Randomised traffic including out-of-range channels and enable toggles.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 99) < 3) enable = ~enable;
      cyc(enable, ($urandom_range(0, 99) < 60), $urandom_range(0, 11),
          $urandom_range(0, 4095), ($urandom_range(0, 99) < 75));
    end

    // Discard counter saturation.
    cyc(1, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 1);
    for (int i = 0; i < 65540; i++) cyc(1, 1, 17, i, 1);
    check("a_discard_sat", int'(a_discard_cnt), 65535);

    // Reset mid-accumulation, then a fresh block on re-enable.
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 1);
    cyc(1, 1, 5, 4095, 1);
    cyc(1, 1, 5, 4095, 1);
    reset_reset = 1'b1;
    #1;
    model_reset();
    check_reset_values();
    @(posedge clk_clk);
    #1;
    reset_reset = 1'b0;
    cyc(0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 1);
    for (int i = 0; i < 16; i++) cyc(1, 1, 5, 16 * i, 1);
    check("a_fresh_data", int'(a_res_data), 120);

    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 1);
    check("a_drain", exp_a.size(), 0);
    check("b_drain", exp_b.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adc_channel_averager.md
# adc_channel_averager

Parametrised successor to the on-chip modular ADC wrapper. It owns the sequencer CSR, starting and stopping continuous conversion itself. It accumulates the response stream per channel and emits one averaged sample per channel every 2^AVG_LOG2 conversions on a valid/ready result port. It sits between the ADC IP instance and the measurement logic, replacing ad-hoc CSR pokes and raw-sample handling.

## Interface
- NUM_CH, 9: number of channel slots (1..18); response channels >= NUM_CH are discarded.
- DATA_W, 12: ADC response data width.
- CH_W, 5: response channel width.
- AVG_LOG2, 4: log2 of samples averaged per result (0..8); 0 = pass-through.
- ACC_W, DATA_W+AVG_LOG2: accumulator width (derived, not overridable).

Ports:
- clk_clk  in  1  system clock, same clock as ADC IP clk_clk.
- reset_reset  in  1  asynchronous, active-high reset.
- enable  in  1  level; 1 = run continuous conversion, 0 = stop.
- rsp_valid  in  1  ADC response valid.
- rsp_channel  in  CH_W  ADC response channel.
- rsp_data  in  DATA_W  ADC response data.
- csr_address  out  1  sequencer CSR address (always 0, command register).
- csr_write  out  1  sequencer CSR write strobe, single-cycle.
- csr_writedata  out  32  sequencer command word.
- csr_read  out  1  tied 0.
- res_valid  out  1  averaged result available.
- res_ready  in  1  consumer accepts result.
- res_channel  out  CH_W  channel of result.
- res_data  out  DATA_W  averaged value.
- running  out  1  FSM in RUN.
- overrun  out  1  sticky; a completed result was dropped. Cleared only by reset or a rising edge of enable.
- discard_cnt  out  16  saturating count of responses with channel >= NUM_CH.

## Operation
- FSM states: IDLE, START, RUN, STOP.
  - IDLE -> START when enable=1.
  - START: csr_write=1, csr_writedata=0x0000_0001 (run=1, mode=continuous) for exactly one cycle; START -> RUN.
  - RUN -> STOP when enable=0.
  - STOP: csr_write=1, csr_writedata=0x0000_0000 for one cycle; STOP -> IDLE.
- Responses are accumulated only in RUN. In IDLE, START and STOP they are ignored and not counted.
- Entering IDLE clears all accumulators and sample counters. The output register is not cleared; a pending result stays until accepted.
- Per slot: acc[ACC_W], cnt[AVG_LOG2].
  - Accepted sample with cnt < 2^AVG_LOG2-1: acc += rsp_data and cnt++.
  - Accepted sample with cnt = 2^AVG_LOG2-1: result = (acc+rsp_data) >> AVG_LOG2, truncated with no rounding; then acc=0, cnt=0.
- Output register is one entry.
  - If a result completes while res_valid=1 and res_ready=0, the new result is dropped and overrun is set.
  - If res_valid=1 and res_ready=1 on the completion edge, the new result is loaded and overrun is not set.
- discard_cnt saturates at 0xFFFF.
- Reset values: state IDLE, csr_write 0, csr_writedata 0, res_valid 0, res_channel 0, res_data 0, running 0, overrun 0, discard_cnt 0, all acc and cnt 0.

## Timing
- enable rises at edge N: START at N+1, csr_write high for cycle N+1, running=1 from N+2.
- A completing sample at edge E gives res_valid=1 after E. Latency is 1 cycle.
- res_valid holds, with res_channel and res_data stable, until an edge with res_ready=1.
- enable falling during START: START still completes and RUN is left on the next edge. A run and a stop write are always paired.
- Reset mid-operation: all state returns to reset values immediately. No stop write is issued. Software re-enables to resynchronise the sequencer.

## Structure
- Package adc_avg_pkg holds:
  - FSM state enum;
  - CSR constants CMD_RUN=32'h1 and CMD_STOP=32'h0;
  - CSR address constant.
- Sub-module adc_seq_ctrl holds the FSM and CSR strobes. Slot accumulators and the output register stay in the top level.

## Test plan
- Reset then enable=1: exactly one csr_write with writedata 0x1 on the cycle after enable, running=1 one cycle later. enable=0 gives one write of 0x0, then IDLE.
- AVG_LOG2=2, channel 3 samples 100,101,102,104: one result with channel 3, data 101 (407>>2), res_valid 1 cycle after the 4th sample.
- Interleaved ch0=4000 and ch1=10, 16 samples each at AVG_LOG2=4: results ch0=4000 and ch1=10, in completion order.
- Hold res_ready=0 while a second result completes: first result preserved, overrun=1. Completion on the same edge as the accept: no overrun.
- rsp_channel=17 with NUM_CH=9: sample ignored, discard_cnt increments. Preload discard_cnt to 0xFFFF: it stays at 0xFFFF.
- Assert reset_reset mid-accumulation (cnt=2): all outputs at reset values asynchronously. After re-enable, the first result uses fresh samples only.
